// File: rtl/store_buffer_unit_pkg.sv
// Shared store encodings and the store-buffer entry layout.
package store_buffer_unit_pkg;

    localparam logic [2:0] STR_NOP = 3'b000;
    localparam logic [2:0] STR_SB  = 3'b001;
    localparam logic [2:0] STR_SH  = 3'b010;
    localparam logic [2:0] STR_SW  = 3'b011;

    // Entry address field is sized for the widest supported byte address.
    localparam int SB_ADDR_W = 32;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [31:0]          wdata;
        logic [3:0]           be;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_unit_align.sv
// store_align: turns a decoded store plus its byte lane into byte enables and replicated data.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is used.
module store_align
    import store_buffer_unit_pkg::*;
(
    input  logic [2:0]  store_control,
    input  logic [1:0]  lane,
    input  logic [31:0] rs2_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic        is_store
);

    always_comb begin
        be         = 4'b0000;
        wdata      = 32'h0;
        misaligned = 1'b0;
        is_store   = 1'b0;
        case (store_control)
            STR_SB: begin
                is_store = 1'b1;
                be       = 4'b0001 << lane;
                wdata    = {4{rs2_data[7:0]}};
            end
            STR_SH: begin
                is_store   = 1'b1;
                misaligned = lane[0];
                be         = 4'b0011 << {lane[1], 1'b0};
                wdata      = {2{rs2_data[15:0]}};
            end
            STR_SW: begin
                is_store   = 1'b1;
                misaligned = |lane;
                be         = 4'b1111;
                wdata      = rs2_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_buffer_unit.sv
// store_buffer_unit: computes store EA, checks alignment, queues stores and drains them to memory.
// Latency: a store accepted into an empty buffer is presented on mem_req the next cycle.
// Backpressure: st_ready drops at DEPTH entries (registered count only); head held until mem_ack.
module store_buffer_unit
    import store_buffer_unit_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [2:0]               store_control,
    input  logic [31:0]              rs1_data,
    input  logic [31:0]              rs2_data,
    input  logic [11:0]              imm,
    output logic                     misalign_exc,
    output logic [ADDR_W-1:0]        exc_addr,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    input  logic                     mem_ack,
    output logic                     sb_empty,
    output logic [$clog2(DEPTH):0]   sb_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              empty_q, empty_d;
    logic              exc_q, exc_d;
    logic [ADDR_W-1:0] exc_addr_q, exc_addr_d;
    sb_entry_t         entries_q [DEPTH];
    sb_entry_t         entries_d [DEPTH];

    logic [ADDR_W-1:0] ea;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic              al_misaligned;
    logic              al_is_store;
    logic              accept;
    logic              enq;
    logic              deq;
    sb_entry_t         head;

    // Address arithmetic wraps silently; there is no overflow trap.
    assign ea = ADDR_W'(rs1_data) + ADDR_W'({{20{imm[11]}}, imm});

    store_align u_align (
        .store_control (store_control),
        .lane          (ea[1:0]),
        .rs2_data      (rs2_data),
        .be            (al_be),
        .wdata         (al_wdata),
        .misaligned    (al_misaligned),
        .is_store      (al_is_store)
    );

    assign st_ready = (count_q != CW'(DEPTH));
    assign accept   = st_valid & st_ready;
    assign enq      = accept & al_is_store & ~al_misaligned;
    assign deq      = ~empty_q & mem_ack;

    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (enq) begin
            entries_d[wr_ptr_q] = '{addr: SB_ADDR_W'(ea), wdata: al_wdata, be: al_be};
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        empty_d    = (count_d == '0);
        exc_d      = accept & al_is_store & al_misaligned;
        exc_addr_d = exc_d ? ea : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            exc_q      <= 1'b0;
            exc_addr_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            exc_q      <= exc_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    // Payload storage needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    assign head         = entries_q[rd_ptr_q];
    assign mem_req      = ~empty_q;
    assign mem_addr     = ADDR_W'(head.addr);
    assign mem_wdata    = head.wdata;
    assign mem_be       = head.be;
    assign sb_empty     = empty_q;
    assign sb_count     = count_q;
    assign misalign_exc = exc_q;
    assign exc_addr     = exc_addr_q;

endmodule

// File: tb/tb_store_buffer_unit.sv
// Bench for store_buffer_unit: directed scenarios plus a randomized run against a queue model.
module tb_store_buffer_unit;
    import store_buffer_unit_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  store_control;
    logic [31:0] rs1_data, rs2_data;
    logic [11:0] imm;
    logic        misalign_exc;
    logic [31:0] exc_addr;
    logic        mem_req;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        sb_empty;
    logic [2:0]  sb_count;

    int n_cmp = 0;
    int n_err = 0;

    sb_entry_t   mq[$];
    bit          exp_exc = 0;
    logic [31:0] exp_exc_addr = '0;

    store_buffer_unit #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
        .store_control(store_control), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .misalign_exc(misalign_exc), .exc_addr(exc_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .sb_empty(sb_empty), .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    // Reference formatting from the architectural rules, using plain arithmetic.
    function automatic void ref_fmt(input logic [2:0] ctl, input logic [31:0] rs1,
                                    input logic [31:0] rs2, input logic [11:0] im,
                                    output sb_entry_t e, output bit mis, output bit st);
        int unsigned lane;
        e.addr  = rs1 + 32'($signed(im));
        lane    = e.addr % 4;
        e.be    = 4'h0;
        e.wdata = 32'h0;
        mis     = 0;
        st      = 1;
        if (ctl == STR_SB) begin
            e.be    = 4'(1 << lane);
            e.wdata = {24'h0, rs2[7:0]} * 32'h01010101;
        end else if (ctl == STR_SH) begin
            mis     = (e.addr % 2) != 0;
            e.be    = 4'(3 << (lane & 2));
            e.wdata = {16'h0, rs2[15:0]} * 32'h00010001;
        end else if (ctl == STR_SW) begin
            mis     = lane != 0;
            e.be    = 4'hF;
            e.wdata = rs2;
        end else begin
            st = 0;
        end
    endfunction

    task automatic drive(input bit v, input logic [2:0] ctl, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [11:0] im, input bit ack);
        st_valid = v; store_control = ctl; rs1_data = rs1; rs2_data = rs2; imm = im; mem_ack = ack;
    endtask

    // Advance one clock and move the model by the same edge.
    task automatic step();
        sb_entry_t e;
        bit mis, st, acc, dq, rst;
        ref_fmt(store_control, rs1_data, rs2_data, imm, e, mis, st);
        acc = st_valid && (mq.size() != DEPTH);
        dq  = (mq.size() != 0) && mem_ack;
        rst = reset;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            exp_exc      = 0;
            exp_exc_addr = '0;
        end else begin
            if (dq) void'(mq.pop_front());
            if (acc && st && !mis) mq.push_back(e);
            exp_exc      = acc && st && mis;
            exp_exc_addr = exp_exc ? e.addr : 32'h0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, STR_NOP, 0, 0, 0, 0);
        step(); step();
        reset = 1'b0;
        n_cmp++; if (sb_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", sb_count); end
        n_cmp++; if (sb_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", sb_empty); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        n_cmp++; if (misalign_exc !== 1'b0 || exc_addr !== 32'h0) begin
            n_err++; $display("FAIL reset_exc got %b/%h want 0/0", misalign_exc, exc_addr); end
        n_cmp++; if (st_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", st_ready); end
    endtask

    task automatic test_sb_basic();
        drive(1, STR_SB, 32'h1000, 32'hAABBCCDD, 12'd3, 0);
        step();
        drive(0, STR_NOP, 0, 0, 0, 0);
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL sb_req got %b want 1", mem_req); end
        n_cmp++; if (mem_addr !== 32'h1003 || mem_be !== 4'b1000 || mem_wdata !== 32'hDDDDDDDD) begin
            n_err++; $display("FAIL sb_fmt got %h/%b/%h want 00001003/1000/dddddddd", mem_addr, mem_be, mem_wdata); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        n_cmp++; if (sb_empty !== 1'b1 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL sb_retire got empty=%b req=%b want 1/0", sb_empty, mem_req); end
    endtask

    task automatic test_sh_misalign();
        drive(1, STR_SH, 32'h2000, 32'h00001234, 12'hFFE, 0);
        step();
        n_cmp++; if (mem_addr !== 32'h1FFE || mem_be !== 4'b1100 || mem_wdata !== 32'h12341234) begin
            n_err++; $display("FAIL sh_fmt got %h/%b/%h want 00001ffe/1100/12341234", mem_addr, mem_be, mem_wdata); end
        drive(1, STR_SW, 32'h2000, 32'hCAFEF00D, 12'd2, 0);
        step();
        drive(0, STR_NOP, 0, 0, 0, 0);
        n_cmp++; if (misalign_exc !== 1'b1 || exc_addr !== 32'h2002) begin
            n_err++; $display("FAIL sw_misalign got %b/%h want 1/00002002", misalign_exc, exc_addr); end
        n_cmp++; if (sb_count !== 3'd1) begin n_err++; $display("FAIL misalign_count got %0d want 1", sb_count); end
        step();
        n_cmp++; if (misalign_exc !== 1'b0 || exc_addr !== 32'h0) begin
            n_err++; $display("FAIL exc_pulse got %b/%h want 0/0", misalign_exc, exc_addr); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        n_cmp++; if (sb_empty !== 1'b1) begin n_err++; $display("FAIL sh_drain got %b want 1", sb_empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, STR_SW, 32'h3000 + 32'(4 * i), 32'h11110000 + 32'(i), 12'd0, 0);
            step();
        end
        n_cmp++; if (sb_count !== 3'(DEPTH) || st_ready !== 1'b0) begin
            n_err++; $display("FAIL fill got count=%0d ready=%b want %0d/0", sb_count, st_ready, DEPTH); end
        drive(1, STR_SW, 32'h3FF0, 32'hDEADBEEF, 12'd0, 0);
        step();
        n_cmp++; if (sb_count !== 3'(DEPTH)) begin n_err++; $display("FAIL full_reject got %0d want %0d", sb_count, DEPTH); end
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000 || mem_wdata !== 32'h11110000 || mem_be !== 4'hF) begin
            n_err++; $display("FAIL full_hold got %b/%h/%h/%b want 1/00003000/11110000/1111",
                              mem_req, mem_addr, mem_wdata, mem_be); end
    endtask

    task automatic test_full_ack();
        logic [31:0] seq [4];
        drive(1, STR_SW, 32'h3010, 32'h22220000, 12'd0, 1);
        step();
        n_cmp++; if (sb_count !== 3'(DEPTH - 1) || mem_addr !== 32'h3004 || st_ready !== 1'b1) begin
            n_err++; $display("FAIL full_ack got count=%0d addr=%h ready=%b want %0d/00003004/1",
                              sb_count, mem_addr, st_ready, DEPTH - 1); end
        mem_ack = 1'b0;
        step();
        n_cmp++; if (sb_count !== 3'(DEPTH)) begin n_err++; $display("FAIL after_full_accept got %0d want %0d", sb_count, DEPTH); end
        drive(0, STR_NOP, 0, 0, 0, 1);
        seq[0] = 32'h3004; seq[1] = 32'h3008; seq[2] = 32'h300C; seq[3] = 32'h3010;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (mem_addr !== seq[k]) begin n_err++; $display("FAIL full_drain_order[%0d] got %h want %h", k, mem_addr, seq[k]); end
            step();
        end
        mem_ack = 1'b0;
        n_cmp++; if (sb_empty !== 1'b1) begin n_err++; $display("FAIL full_drain_empty got %b want 1", sb_empty); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            d = $urandom;
            drive(1, STR_SW, 32'h5000 + 32'(4 * i), d, 12'd0, 1);
            step();
            n_cmp++; if (sb_count !== 3'd1) begin n_err++; $display("FAIL b2b_count[%0d] got %0d want 1", i, sb_count); end
            n_cmp++; if (mem_addr !== 32'h5000 + 32'(4 * i) || mem_wdata !== d) begin
                n_err++; $display("FAIL b2b_order[%0d] got %h/%h want %h/%h", i, mem_addr, mem_wdata, 32'h5000 + 32'(4 * i), d); end
        end
        drive(0, STR_NOP, 0, 0, 0, 1);
        step();
        mem_ack = 1'b0;
        n_cmp++; if (sb_empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty got %b want 1", sb_empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1, STR_SB, 32'h6000 + 32'(i), 32'h000000A0 + 32'(i), 12'd0, 0);
            step();
        end
        n_cmp++; if (sb_count !== 3'd3) begin n_err++; $display("FAIL pre_reset_count got %0d want 3", sb_count); end
        drive(0, STR_NOP, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (sb_count !== 3'd0 || mem_req !== 1'b0 || sb_empty !== 1'b1) begin
            n_err++; $display("FAIL mid_reset got count=%0d req=%b empty=%b want 0/0/1", sb_count, mem_req, sb_empty); end
        drive(1, STR_NOP, 32'h7000, 32'h1, 12'd0, 0);
        step();
        drive(0, STR_NOP, 0, 0, 0, 0);
        n_cmp++; if (sb_count !== 3'd0 || mem_req !== 1'b0 || misalign_exc !== 1'b0) begin
            n_err++; $display("FAIL nop_drop got count=%0d req=%b exc=%b want 0/0/0", sb_count, mem_req, misalign_exc); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), $urandom, $urandom,
                  12'($urandom), $urandom_range(0, 1) == 1);
            step();
            n_cmp++; if (sb_count !== 3'(mq.size()) || sb_empty !== (mq.size() == 0)) begin
                n_err++; $display("FAIL rnd_count[%0d] got %0d/%b want %0d", c, sb_count, sb_empty, mq.size()); end
            n_cmp++; if (mem_req !== (mq.size() != 0) || st_ready !== (mq.size() != DEPTH)) begin
                n_err++; $display("FAIL rnd_flags[%0d] got req=%b ready=%b qsize=%0d", c, mem_req, st_ready, mq.size()); end
            n_cmp++; if (misalign_exc !== exp_exc || exc_addr !== exp_exc_addr) begin
                n_err++; $display("FAIL rnd_exc[%0d] got %b/%h want %b/%h", c, misalign_exc, exc_addr, exp_exc, exp_exc_addr); end
            if (mq.size() != 0) begin
                n_cmp++; if (mem_addr !== mq[0].addr || mem_wdata !== mq[0].wdata || mem_be !== mq[0].be) begin
                    n_err++; $display("FAIL rnd_head[%0d] got %h/%h/%b want %h/%h/%b", c, mem_addr, mem_wdata, mem_be,
                                      mq[0].addr, mq[0].wdata, mq[0].be); end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, STR_NOP, 0, 0, 0, 0);
        test_reset();
        test_sb_basic();
        test_sh_misalign();
        test_fill();
        test_full_ack();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
